// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
//   state_t  : controller states (IDLE, CALC, DONE)
//   MAX_W    : widest operand the helper functions support (WIDTH <= MAX_W)
//   abs_w    : magnitude of a w-bit operand, optionally two's complement
//   neg_2w   : two's complement negate of a double-width product
package seq_mult_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // val carries a w-bit operand zero-extended to MAX_W bits. The magnitude of
  // -2^(w-1) is 2^(w-1), which still fits in w unsigned bits.
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] val,
                                             input logic             is_signed,
                                             input int unsigned      w);
    logic [MAX_W-1:0] mask;
    logic             msb;
    mask = '1;
    mask = mask >> (MAX_W - w);
    msb  = |((val >> (w - 1)) & MAX_W'(1));
    if (is_signed && msb) begin
      return (~val + MAX_W'(1)) & mask;
    end
    return val & mask;
  endfunction

  // Callers truncate the result to their own 2*WIDTH bits.
  function automatic logic [2*MAX_W-1:0] neg_2w(input logic [2*MAX_W-1:0] val);
    return ~val + (2*MAX_W)'(1);
  endfunction

endpackage

// File: rtl/seq_mult_absval.sv
// Operand capture stage: on load, registers the magnitude and sign of one
// operand so the shift-add core always works on unsigned values.
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high; clears mag and sign
//   load       : capture val this edge (the accept edge)
//   is_signed  : val is two's complement
//   val        : operand, WIDTH bits
//   mag        : registered magnitude, WIDTH bits
//   sign       : registered sign (0 when unsigned)
module seq_mult_absval
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] mag,
  output logic             sign
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag  <= '0;
      sign <= 1'b0;
    end else if (load) begin
      mag  <= WIDTH'(abs_w(MAX_W'(val), is_signed, WIDTH));
      sign <= is_signed & val[WIDTH-1];
    end
  end

endmodule

// File: rtl/seq_mult_param.sv
// Parametrised sequential shift-add multiplier (WIDTH x WIDTH -> 2*WIDTH).
// Operands are accepted on a valid/ready handshake in IDLE, one multiplier
// bit is consumed per edge in CALC, and the product is held in DONE until the
// consumer takes it. Signed mode works on magnitudes and fixes the sign at the
// end. WIDTH must be >= 2 and <= seq_mult_pkg::MAX_W.
// Build option: define EARLY_TERM_EN to finish as soon as the remaining
// multiplier bits are all zero (latency = max(1, msb index of |num_2| + 1)).
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high
//   in_valid   : operand transaction offered
//   in_ready   : operands can be accepted (IDLE)
//   in_signed  : operands are two's complement
//   num_1      : multiplicand, WIDTH bits
//   num_2      : multiplier, WIDTH bits
//   out_valid  : result valid and held (DONE)
//   out_ready  : consumer accepts result
//   result     : product, 2*WIDTH bits
//   busy       : multiplication in progress (CALC)
module seq_mult_param
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   num_1,
  input  logic [WIDTH-1:0]   num_2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t               state;
  state_t               state_nxt;
  logic                 accept;
  logic [WIDTH-1:0]     mc;
  logic [WIDTH-1:0]     mp;
  logic                 sign_1;
  logic                 sign_2;
  logic                 neg;
  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     lo;
  logic [CNT_W-1:0]     cnt;
  logic                 bit_now;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH:0]     full;
  logic                 finish;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   result_nxt;

  assign accept = in_valid & in_ready;
  assign neg    = sign_1 ^ sign_2;

  seq_mult_absval #(.WIDTH(WIDTH)) u_abs_mc (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .is_signed (in_signed),
    .val       (num_1),
    .mag       (mc),
    .sign      (sign_1)
  );

  seq_mult_absval #(.WIDTH(WIDTH)) u_abs_mp (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .is_signed (in_signed),
    .val       (num_2),
    .mag       (mp),
    .sign      (sign_2)
  );

  // The multiplier magnitude stays in u_abs_mp; the current bit is picked
  // with mp >> cnt instead of shifting it through lo. lo therefore starts at
  // zero and its not-yet-filled low bits are zero rather than leftover
  // multiplier bits; every result path shifts those bits out, so the product
  // is identical to the classic {hi,lo} = {0,mp} formulation.
  always_comb begin
    bit_now = |((mp >> cnt) & WIDTH'(1));
    addend  = bit_now ? mc : '0;
    sum     = {1'b0, hi} + {1'b0, addend};
    full    = {sum, lo};
`ifdef EARLY_TERM_EN
    // Done once no set multiplier bits remain above the one consumed now.
    // For num_2 = 0 this fires on the first edge with a zero product.
    finish  = ((mp >> (cnt + CNT_W'(1))) == '0);
    prod    = (2*WIDTH)'(full >> (CNT_W'(WIDTH) - cnt));
`else
    finish  = (cnt == CNT_W'(WIDTH - 1));
    prod    = (2*WIDTH)'(full >> 1);
`endif
    result_nxt = neg ? (2*WIDTH)'(neg_2w((2*MAX_W)'(prod))) : prod;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (finish) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            hi  <= '0;
            lo  <= '0;
            cnt <= '0;
          end
        end
        CALC: begin
          hi  <= sum[WIDTH:1];
          lo  <= {sum[0], lo[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
          if (finish) begin
            result <= result_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param: WIDTH=8 and WIDTH=16 instances,
// directed corner cases plus random operands against an arithmetic model.
// Latency expectations follow the EARLY_TERM_EN build option.
module tb_seq_mult_param;

`ifdef EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        iv8, ir8, is8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] r8;
  logic        iv16, ir16, is16, ov16, or16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] r16;

  seq_mult_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .in_signed(is8),
    .num_1(a8), .num_2(b8), .out_valid(ov8), .out_ready(or8), .result(r8),
    .busy(busy8)
  );

  seq_mult_param #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .in_signed(is16),
    .num_1(a16), .num_2(b16), .out_valid(ov16), .out_ready(or16), .result(r16),
    .busy(busy16)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint sext(input int w, input longint unsigned v);
    longint unsigned m;
    longint unsigned x;
    m = (64'd1 << w) - 64'd1;
    x = v & m;
    if (((x >> (w - 1)) & 64'd1) != 0) return longint'(x) - longint'(64'd1 << w);
    return longint'(x);
  endfunction

  function automatic longint unsigned ref_prod(input int w, input bit sgn,
                                               input longint unsigned a, input longint unsigned b);
    longint p;
    longint unsigned m;
    m = (64'd1 << w) - 64'd1;
    if (sgn) p = sext(w, a) * sext(w, b);
    else     p = longint'(a & m) * longint'(b & m);
    return $unsigned(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  function automatic int ref_lat(input int w, input bit sgn, input longint unsigned b);
    longint mag;
    int     top;
    mag = sgn ? sext(w, b) : longint'(b & ((64'd1 << w) - 64'd1));
    if (mag < 0) mag = -mag;
    top = 0;
    for (int i = 0; i < w; i++) if (((mag >> i) & 1) != 0) top = i + 1;
    if (!EARLY) return w;
    return (top < 1) ? 1 : top;
  endfunction

  // ---------------- DUT access ----------------
  task automatic drive(input int w, input bit v, input bit s,
                       input longint unsigned a, input longint unsigned b);
    if (w == 8) begin
      iv8 = v; is8 = s; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      iv16 = v; is16 = s; a16 = a[15:0]; b16 = b[15:0];
    end
  endtask

  task automatic set_ordy(input int w, input bit r);
    if (w == 8) or8 = r; else or16 = r;
  endtask

  function automatic bit get_ov(input int w);   return (w == 8) ? ov8 : ov16; endfunction
  function automatic bit get_ir(input int w);   return (w == 8) ? ir8 : ir16; endfunction
  function automatic bit get_busy(input int w); return (w == 8) ? busy8 : busy16; endfunction
  function automatic longint unsigned get_res(input int w);
    return (w == 8) ? 64'(r8) : 64'(r16);
  endfunction

  // One full transaction: accept, measure latency, hold, consume.
  task automatic do_op(input int w, input bit sgn, input longint unsigned a,
                       input longint unsigned b, input longint unsigned exp,
                       input int hold, input string tag);
    int lat;
    @(negedge clk);
    check({tag, " in_ready"}, 64'(get_ir(w)), 64'd1);
    drive(w, 1'b1, sgn, a, b);
    @(posedge clk);
    #1;
    // Operands change after the accept edge; they must not matter.
    drive(w, 1'b0, ~sgn, 64'($urandom), 64'($urandom));
    check({tag, " busy"}, 64'(get_busy(w)), 64'd1);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!get_ov(w) && lat < 40);
    check({tag, " latency"}, 64'(lat), 64'(ref_lat(w, sgn, b)));
    check({tag, " result"}, get_res(w), exp);
    repeat (hold) begin
      @(posedge clk);
      #1;
      check({tag, " hold valid"}, 64'(get_ov(w)), 64'd1);
      check({tag, " hold result"}, get_res(w), exp);
    end
    @(negedge clk);
    set_ordy(w, 1'b1);
    @(posedge clk);
    #1;
    set_ordy(w, 1'b0);
    check({tag, " valid drop"}, 64'(get_ov(w)), 64'd0);
    check({tag, " ready back"}, 64'(get_ir(w)), 64'd1);
  endtask

  initial begin
    longint unsigned ra, rb;
    bit              rs;
    reset = 1'b1;
    drive(8, 1'b0, 1'b0, 0, 0);
    drive(16, 1'b0, 1'b0, 0, 0);
    or8 = 1'b0;
    or16 = 1'b0;
    #12;
    check("rst8 result", get_res(8), 64'd0);
    check("rst8 valid", 64'(ov8), 64'd0);
    check("rst8 busy", 64'(busy8), 64'd0);
    check("rst8 ready", 64'(ir8), 64'd1);
    check("rst16 result", get_res(16), 64'd0);
    check("rst16 valid", 64'(ov16), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op(8, 1'b0, 241, 187, 64'hB00B, 5, "u241x187");
    do_op(8, 1'b1, 64'h97, 67, 64'hE485, 0, "s-105x67");
    do_op(8, 1'b1, 64'hDC, 83, 64'hF454, 1, "s-36x83");
    do_op(8, 1'b1, 64'h80, 64'h80, 64'h4000, 0, "s-128x-128");
    do_op(8, 1'b0, 255, 255, 64'hFE01, 0, "u255x255");
    do_op(8, 1'b1, 255, 255, 64'h0001, 0, "s-1x-1");
    do_op(8, 1'b0, 64'h5A, 0, 64'd0, 0, "u90x0");
    do_op(8, 1'b0, 7, 3, 64'd21, 0, "u7x3");

    // Abort mid-calculation with an asynchronous reset (previous result is 21).
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 200, 100);
    @(posedge clk);
    #1;
    drive(8, 1'b0, 1'b0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("abort busy before", 64'(busy8), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check("abort valid", 64'(ov8), 64'd0);
    check("abort busy", 64'(busy8), 64'd0);
    check("abort result", get_res(8), 64'd0);
    check("abort ready", 64'(ir8), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    do_op(8, 1'b0, 10, 10, 64'd100, 0, "u10x10");

    do_op(16, 1'b1, 64'h8000, 64'h7FFF, 64'hC0008000, 2, "s16 min x max");

    for (int i = 0; i < 1000; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 64'($urandom) & 64'hFFFF;
      rb = 64'($urandom) & 64'hFFFF;
      if ($urandom_range(0, 15) == 0) ra = 64'h8000;
      if ($urandom_range(0, 15) == 0) rb = 64'($urandom_range(0, 3));
      do_op(16, rs, ra, rb, ref_prod(16, rs, ra, rb), int'($urandom_range(0, 2)), "rand16");
    end
    for (int i = 0; i < 200; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 64'($urandom) & 64'hFF;
      rb = 64'($urandom) & 64'hFF;
      if ($urandom_range(0, 15) == 0) rb = 64'h80;
      do_op(8, rs, ra, rb, ref_prod(8, rs, ra, rb), int'($urandom_range(0, 1)), "rand8");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
